// File: rtl/calc_pkg.sv
// Shared calculator definitions: key event encoding and function-key indices.
package calc_pkg;

    typedef enum logic {
        KEY_OP_DIGIT = 1'b0,
        KEY_OP_FUNC  = 1'b1
    } key_op_t;

    localparam int unsigned NUM_DIGITS = 10;
    localparam int unsigned NUM_FUNCS  = 8;
    localparam int unsigned NUM_KEYS   = NUM_DIGITS + NUM_FUNCS;

    localparam logic [3:0] FN_SIGN = 4'd0;
    localparam logic [3:0] FN_ADD  = 4'd1;
    localparam logic [3:0] FN_SUB  = 4'd2;
    localparam logic [3:0] FN_EQU  = 4'd7;

    typedef struct packed {
        key_op_t    op;
        logic [3:0] code;
    } key_event_t;

endpackage

// File: rtl/debounce_cell.sv
// One push button: 2-flop synchroniser, debounce counter, stable level and
// a registered one-cycle pulse on each accepted 0->1 transition.
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            press    <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            // Any return to the stable level restarts the count, so bounce is ignored.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/key_event_encoder.sv
// Calculator key front end: debounced press events, priority-selected and
// queued in a small FIFO consumed through a valid/ready handshake.
module key_event_encoder
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] swp,
    input  logic [7:0] swd,
    input  logic       clr,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_op,
    output logic [3:0] key_code,
    output logic       key_drop
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] btn;

    assign btn = {swd, swp};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[i]),
            .press(press[i])
        );
    end

    key_event_t ev;
    logic       ev_any;
    logic       ev_multi;

    // Digits occupy the low bits, so a plain lowest-index scan gives digit priority.
    always_comb begin
        ev       = '{op: KEY_OP_DIGIT, code: 4'd0};
        ev_any   = 1'b0;
        ev_multi = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (press[i]) begin
                if (ev_any) begin
                    ev_multi = 1'b1;
                end else begin
                    ev_any = 1'b1;
                    if (i < NUM_DIGITS) begin
                        ev = '{op: KEY_OP_DIGIT, code: 4'(i)};
                    end else begin
                        ev = '{op: KEY_OP_FUNC, code: 4'(i - NUM_DIGITS)};
                    end
                end
            end
        end
    end

    key_event_t mem [FIFO_DEPTH];
    key_event_t head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = key_valid & key_ready;
    assign push  = ev_any & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            key_drop <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            key_drop <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= ev;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (ev_multi || (ev_any && !push)) begin
                key_drop <= 1'b1;
            end
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign key_valid = ~empty;
    assign key_op    = head.op;
    assign key_code  = head.code;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
module tb_key_event_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] swp;
    logic [7:0] swd;
    logic       clr;
    logic       key_valid;
    logic       key_ready;
    logic       key_op;
    logic [3:0] key_code;
    logic       key_drop;

    int checks = 0;
    int errors = 0;
    logic [4:0] cap_q [$];

    key_event_encoder #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .swp      (swp),
        .swd      (swd),
        .clr      (clr),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_op   (key_op),
        .key_code (key_code),
        .key_drop (key_drop)
    );

    always #5 clk = ~clk;

    // Record every accepted event as {op, code}.
    always @(negedge clk) begin
        if (rst && key_valid && key_ready) cap_q.push_back({key_op, key_code});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // exp[0] is the first expected event.
    task automatic check_events(input string tag, input int n, input logic [4:0][4:0] exp);
        logic [4:0] obs;
        check({tag, "_count"}, cap_q.size(), n);
        for (int i = 0; i < n; i++) begin
            obs = (i < cap_q.size()) ? cap_q[i] : 5'h1f;
            check($sformatf("%s_ev%0d", tag, i), obs, exp[i]);
        end
        cap_q.delete();
    endtask

    initial begin
        rst       = 1'b0;
        swp       = '0;
        swd       = '0;
        clr       = 1'b0;
        key_ready = 1'b0;
        idle(3);
        check("rst_valid", key_valid, 1'b0);
        check("rst_op", key_op, 1'b0);
        check("rst_code", key_code, 4'd0);
        check("rst_drop", key_drop, 1'b0);
        rst = 1'b1;
        idle(2);

        // Single digit press: latency and single event while held.
        key_ready = 1'b1;
        swp[2]    = 1'b1;
        idle(7);
        check("t2_early", key_valid, 1'b0);
        tick();
        check("t2_valid", key_valid, 1'b1);
        check("t2_op", key_op, 1'b0);
        check("t2_code", key_code, 4'd2);
        tick();
        check("t2_pulse", key_valid, 1'b0);
        idle(11);
        check_events("t2", 1, {5'h0, 5'h0, 5'h0, 5'h0, 5'h02});
        swp = '0;
        idle(12);
        check("t2_release", cap_q.size(), 0);

        // Bounce on swd3 ignored, then a real hold gives one event.
        swd[2] = 1'b1; tick();
        swd[2] = 1'b0; tick();
        swd[2] = 1'b1; tick();
        swd[2] = 1'b0; tick();
        idle(8);
        check("t3_bounce", cap_q.size(), 0);
        swd[2] = 1'b1;
        idle(10);
        check_events("t3", 1, {5'h0, 5'h0, 5'h0, 5'h0, 5'h12});
        swd = '0;
        idle(12);

        // Simultaneous swp4 and swd8.
        swp[4] = 1'b1;
        swd[7] = 1'b1;
        idle(10);
        check_events("t4", 1, {5'h0, 5'h0, 5'h0, 5'h0, 5'h04});
        check("t4_drop", key_drop, 1'b1);
        swp = '0;
        swd = '0;
        idle(12);
        clr = 1'b1; tick(); clr = 1'b0;
        check("t4_clr_drop", key_drop, 1'b0);

        // Back-pressure: five presses, four queued, fifth dropped.
        key_ready = 1'b0;
        swp[2] = 1'b1; idle(2);
        swp[3] = 1'b1; idle(2);
        swp[4] = 1'b1; idle(2);
        swp[5] = 1'b1; idle(2);
        swp[6] = 1'b1;
        idle(10);
        check("t5_valid", key_valid, 1'b1);
        check("t5_head", key_code, 4'd2);
        check("t5_drop", key_drop, 1'b1);
        tick();
        check("t5_stable", key_code, 4'd2);
        key_ready = 1'b1;
        idle(6);
        check_events("t5", 4, {5'h0, 5'h05, 5'h04, 5'h03, 5'h02});
        check("t5_empty", key_valid, 1'b0);
        swp = '0;
        idle(12);
        clr = 1'b1; tick(); clr = 1'b0;

        // Full FIFO, pop on the same edge as a new push.
        key_ready = 1'b0;
        swp[1] = 1'b1; idle(2);
        swp[2] = 1'b1; idle(2);
        swp[3] = 1'b1; idle(2);
        swp[4] = 1'b1;
        idle(10);
        check("t6_full_drop", key_drop, 1'b0);
        swp[7] = 1'b1;
        idle(7);
        check("t6_pre_head", key_code, 4'd1);
        check("t6_pre_drop", key_drop, 1'b0);
        key_ready = 1'b1;
        tick();
        check("t6_drop", key_drop, 1'b0);
        idle(7);
        check_events("t6", 5, {5'h07, 5'h04, 5'h03, 5'h02, 5'h01});
        swp = '0;
        idle(12);

        // Reset while events are queued and swp9 is held.
        key_ready = 1'b0;
        swp[1] = 1'b1; idle(2);
        swp[2] = 1'b1; idle(2);
        swp[3] = 1'b1;
        idle(10);
        check("t7_queued", key_valid, 1'b1);
        swp = 10'h200;
        rst = 1'b0;
        #1;
        check("t7_rst_valid", key_valid, 1'b0);
        idle(3);
        cap_q.delete();
        rst       = 1'b1;
        key_ready = 1'b1;
        idle(7);
        check("t7_early", key_valid, 1'b0);
        tick();
        check("t7_valid", key_valid, 1'b1);
        check("t7_code", key_code, 4'd9);
        check("t7_op", key_op, 1'b0);
        idle(5);
        check_events("t7", 1, {5'h0, 5'h0, 5'h0, 5'h0, 5'h09});
        check("t7_drop", key_drop, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
